mult_seq: RTL and testbench
===========================

Name: mult_seq

Overview:
- Sequential signed 32x32 shift-add multiplier; the multiply counterpart of the iterative divider in the 2-wide processor's multdiv path.
- Shares the divider's control and result interface: ctrl_MULT/ctrl_DIV pulses in, data_result/data_exception/data_resultRDY out. The multdiv wrapper muxes the two units on the same handshake.
- Fixed latency, no early termination, so the issue logic can count stall cycles deterministically.

Parameters:
- WIDTH, 32, operand and result width. Internal product is 2*WIDTH. Iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- data_operandA  input  WIDTH  multiplicand, two's complement; sampled only on the start edge
- data_operandB  input  WIDTH  multiplier, two's complement; sampled only on the start edge
- ctrl_MULT  input  1  start pulse; sampled on the rising edge
- ctrl_DIV  input  1  divider start; for this unit an abort
- data_result  output  WIDTH  low WIDTH bits of the signed product; registered
- data_exception  output  1  signed product does not fit in WIDTH bits; registered
- data_resultRDY  output  1  one-cycle completion strobe

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, all datapath registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Reset mid-operation discards the operation; no RDY is produced.
- States: IDLE, RUN, DONE.
- IDLE, edge with ctrl_MULT=1 and ctrl_DIV=0 (edge E0):
  - mcand = |A| and mplier = |B| (WIDTH-bit unsigned; |-2^31| = 0x80000000).
  - neg = A[MSB]^B[MSB]; acc_hi=0; counter=0; state=RUN.
  - data_resultRDY=0. data_result and data_exception keep their old values.
- RUN, each edge E1..E32:
  - {carry,acc_hi} = acc_hi + (mplier[0] ? mcand : 0).
  - {carry,acc_hi,mplier} shifted right by 1 (65-bit shift).
  - counter++. On the edge where counter reaches WIDTH-1 -> 1 (the 32nd iteration), state=DONE.
- DONE, edge E33:
  - mag = {acc_hi,mplier}; prod = neg ? -mag : mag (2*WIDTH bits).
  - data_result = prod[WIDTH-1:0].
  - data_exception = 1 iff prod[2W-1:WIDTH-1] is not all-equal (i.e. not a sign extension).
  - data_resultRDY=1; state=IDLE.
- data_resultRDY is high exactly one cycle (E33 to E34), then 0. Latency: start edge to RDY edge = 33 cycles, independent of operand values (zero operands included).
- data_result and data_exception hold their values after RDY until the next DONE or reset.
- ctrl_MULT=1 in RUN or DONE (ctrl_DIV=0): restarts with the newly sampled operands, exactly as from IDLE. The old operation produces no RDY.
- ctrl_DIV=1 on any edge: state=IDLE, counter=0, RDY=0; the operation in flight is discarded.
- ctrl_MULT and ctrl_DIV both 1: ctrl_DIV wins (abort); no start.
- Output values, signed interpretation:
  - -2^31 x 1: result 0x80000000, exception 0.
  - -2^31 x -1: result 0x80000000, exception 1.
- Operand inputs may change freely after the start edge without affecting the result.

Test Plan:
- Reset released, ctrl_MULT pulse with A=7, B=6 -> RDY high exactly at E33 for one cycle; data_result=0x0000002A; exception=0; result held 10 cycles later.
- A=-3 (0xFFFFFFFD), B=5 -> result 0xFFFFFFF1, exception 0. A=-4, B=-4 -> 0x00000010, exception 0.
- A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1. A=0x80000000, B=1 -> result 0x80000000, exception 0.
- Start 7x6, then at E10 pulse ctrl_MULT with A=100, B=-2 -> no RDY for the first operation; RDY at E10+33 with result 0xFFFFFF38.
- Start 7x6, ctrl_DIV at E5 -> no RDY ever; data_result keeps its prior value. Simultaneous ctrl_MULT+ctrl_DIV from IDLE -> no start.
- Start 7x6, assert reset=0 asynchronously at E20 between edges -> outputs 0 immediately; after release no RDY; a new start behaves normally.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential signed WIDTH x WIDTH shift-add multiplier with a fixed latency of WIDTH+1 cycles.
// Shares the divider's start/abort/result handshake so the multdiv wrapper can mux the two units.
module mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   counter_q, counter_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
    logic              neg_q, neg_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              exception_q, exception_d;
    logic              rdy_q, rdy_d;

    logic [WIDTH-1:0]   abs_a, abs_b, addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mag, prod;
    logic [WIDTH:0]     prod_top;

    // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign addend = mplier_q[0] ? mcand_q : '0;
    assign sum    = {1'b0, acc_hi_q} + {1'b0, addend};

    assign mag      = {acc_hi_q, mplier_q};
    assign prod     = neg_q ? -mag : mag;
    // Product fits in WIDTH signed bits only if the upper half is a sign extension of bit WIDTH-1.
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_hi_d    = acc_hi_q;
        neg_d       = neg_q;
        result_d    = result_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;

        if (ctrl_DIV) begin
            state_d   = StIdle;
            counter_d = '0;
        end else if (ctrl_MULT) begin
            // A start in any state restarts; the in-flight operation is dropped.
            mcand_d   = abs_a;
            mplier_d  = abs_b;
            neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            acc_hi_d  = '0;
            counter_d = '0;
            state_d   = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    acc_hi_d  = sum[WIDTH:1];
                    mplier_d  = {sum[0], mplier_q[WIDTH-1:1]};
                    counter_d = counter_q + CntW'(1);
                    if (counter_q == LastIter) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    result_d    = prod[WIDTH-1:0];
                    exception_d = !((&prod_top) || !(|prod_top));
                    rdy_d       = 1'b1;
                    state_d     = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            counter_q   <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_hi_q    <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_hi_q    <= acc_hi_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: table of signed products plus restart, abort and reset sequences.
module tb_mult_seq;

    localparam int unsigned WIDTH = 32;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[10];

    mult_seq #(
        .WIDTH(WIDTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called between edges; returns #1 after the start edge (E0) with operands scrambled.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Edge count after the current point at which RDY is first seen, -1 if not within limit.
    task automatic wait_rdy(input int limit, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < limit) begin
            i++;
            @(posedge clock);
            #1;
            if (data_resultRDY) n = i;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int n;
        start(v.a, v.b);
        wait_rdy(45, n);
        check({name, " latency"}, 64'(n), 64'(33));
        check({name, " result"}, 64'(data_result), 64'(v.res));
        check({name, " exception"}, 64'(data_exception), 64'(v.exc));
        @(posedge clock);
        #1;
        check({name, " rdy one cycle"}, 64'(data_resultRDY), 64'(0));
    endtask

    initial begin
        int n;

        vecs[0] = '{32'd7,        32'd6,        32'h0000002A, 1'b0};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0};
        vecs[2] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000010, 1'b0};
        vecs[3] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[5] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[6] = '{32'd0,        32'h00012345, 32'h00000000, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[8] = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
        vecs[9] = '{32'd100,      32'hFFFFFFFE, 32'hFFFFFF38, 1'b0};

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1;
        check("reset result", 64'(data_result), 64'(0));
        check("reset exception", 64'(data_exception), 64'(0));
        check("reset rdy", 64'(data_resultRDY), 64'(0));
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;

        // 7x6 first, then confirm the result is held.
        run_vec("vec0", vecs[0]);
        repeat (10) @(posedge clock);
        #1;
        check("hold result", 64'(data_result), 64'h2A);
        check("hold rdy", 64'(data_resultRDY), 64'(0));

        for (int i = 1; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Restart at E10 with 100 x -2; only the second operation may complete.
        start(32'd7, 32'd6);
        repeat (9) @(posedge clock);
        #1;
        check("restart no early rdy", 64'(data_resultRDY), 64'(0));
        start(32'd100, 32'hFFFFFFFE);
        wait_rdy(45, n);
        check("restart latency", 64'(n), 64'(33));
        check("restart result", 64'(data_result), 64'hFFFFFF38);
        check("restart exception", 64'(data_exception), 64'(0));

        // Abort with ctrl_DIV at E5: no RDY, prior result retained.
        start(32'd7, 32'd6);
        repeat (4) @(posedge clock);
        #1;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        wait_rdy(45, n);
        check("abort no rdy", 64'(n), -64'sd1);
        check("abort result kept", 64'(data_result), 64'hFFFFFF38);

        // Both strobes from IDLE: ctrl_DIV wins, nothing starts.
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        wait_rdy(45, n);
        check("both strobes no start", 64'(n), -64'sd1);
        check("both strobes result kept", 64'(data_result), 64'hFFFFFF38);

        // Leave exception=1 so the asynchronous clear is visible.
        run_vec("pre-reset", vecs[3]);
        start(32'd7, 32'd6);
        repeat (19) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async reset result", 64'(data_result), 64'(0));
        check("async reset exception", 64'(data_exception), 64'(0));
        check("async reset rdy", 64'(data_resultRDY), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        wait_rdy(45, n);
        check("post-reset no rdy", 64'(n), -64'sd1);
        run_vec("post-reset vec", vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
